// File: rtl/i2c_temp_target_pkg.sv
// ============================================================================
// i2c_temp_target_pkg : state encoding, register map and read mux helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2c_temp_target_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_BYTE  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_BYTE  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_e;

   localparam logic [7:0] REG_TEMP_MSB     = 8'h00;
   localparam logic [7:0] REG_TEMP_LSB     = 8'h01;
   localparam logic [7:0] REG_CFG          = 8'h03;
   localparam logic [7:0] REG_ID           = 8'h0B;
   localparam logic [7:0] ID_VALUE_DEFAULT = 8'hCB;
   localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h48;

   function automatic logic [7:0] reg_read(input logic [7:0] ptr,
                                           input logic [7:0] msb,
                                           input logic [7:0] lsb,
                                           input logic [7:0] cfg,
                                           input logic [7:0] id);
      logic [7:0] data;
      case (ptr)
         REG_TEMP_MSB: data = msb;
         REG_TEMP_LSB: data = lsb;
         REG_CFG:      data = cfg;
         REG_ID:       data = id;
         default:      data = 8'h00;
      endcase
      return data;
   endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_temp_target_bus_sync.sv
// ============================================================================
// i2c_bus_sync : 2-FF pad synchronizers, SCL edge and START/STOP detection
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_bus_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic scl_meta_q, scl_sync_q, scl_dly_q;
   logic sda_meta_q, sda_sync_q, sda_dly_q;

   // Reset to the idle bus level so leaving reset never looks like START/STOP
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scl_meta_q <= 1'b1;
         scl_sync_q <= 1'b1;
         scl_dly_q  <= 1'b1;
         sda_meta_q <= 1'b1;
         sda_sync_q <= 1'b1;
         sda_dly_q  <= 1'b1;
      end else begin
         scl_meta_q <= scl_i;
         scl_sync_q <= scl_meta_q;
         scl_dly_q  <= scl_sync_q;
         sda_meta_q <= sda_i;
         sda_sync_q <= sda_meta_q;
         sda_dly_q  <= sda_sync_q;
      end
   end

   assign sda_o      = sda_sync_q;
   assign scl_rise_o = scl_sync_q & ~scl_dly_q;
   assign scl_fall_o = ~scl_sync_q & scl_dly_q;
   assign start_o    = scl_sync_q & scl_dly_q & sda_dly_q & ~sda_sync_q;
   assign stop_o     = scl_sync_q & scl_dly_q & ~sda_dly_q & sda_sync_q;

endmodule

`default_nettype wire

// File: rtl/i2c_temp_target.sv
// ============================================================================
// i2c_temp_target : I2C target exposing a temperature sensor register file
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_temp_target
   import i2c_temp_target_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
   parameter logic [7:0] ID_VALUE = ID_VALUE_DEFAULT
) (
   input  logic       sys_clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   input  logic [7:0] temp_msb,
   input  logic [7:0] temp_lsb,
   output logic [7:0] cfg_reg,
   output logic       busy,
   output logic       xfer_done
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_bus_sync u_sync (
      .clk_i      (sys_clk),
      .rst_i      (rst),
      .scl_i      (scl_in),
      .sda_i      (sda_in),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] shift_q, shift_d, tx_q, tx_d, ptr_q, ptr_d, cfg_q, cfg_d;
   logic [7:0] snap_msb_q, snap_msb_d, snap_lsb_q, snap_lsb_d;
   logic       oe_q, oe_d, busy_q, busy_d, done_q, done_d;
   logic       phase_q, phase_d, rw_q, rw_d, first_q, first_d;
   logic [7:0] rx_byte, rd_data;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 3'd0;
         shift_q    <= 8'h00;
         tx_q       <= 8'h00;
         ptr_q      <= 8'h00;
         cfg_q      <= 8'h00;
         snap_msb_q <= 8'h00;
         snap_lsb_q <= 8'h00;
         oe_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         phase_q    <= 1'b0;
         rw_q       <= 1'b0;
         first_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         cfg_q      <= cfg_d;
         snap_msb_q <= snap_msb_d;
         snap_lsb_q <= snap_lsb_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         phase_q    <= phase_d;
         rw_q       <= rw_d;
         first_q    <= first_d;
      end
   end

   assign rx_byte = {shift_q[6:0], sda_s};
   assign rd_data = reg_read(ptr_q, snap_msb_q, snap_lsb_q, cfg_q, ID_VALUE);

   // phase_q marks the second half of a two-falling-edge ACK window
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      cfg_d      = cfg_q;
      snap_msb_d = snap_msb_q;
      snap_lsb_d = snap_lsb_q;
      oe_d       = oe_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      phase_d    = phase_q;
      rw_d       = rw_q;
      first_d    = first_q;

      if (stop_det) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
         done_d  = 1'b1;
      end else if (start_det) begin
         state_d = ST_ADDR;
         cnt_d   = 3'd0;
         oe_d    = 1'b0;
         busy_d  = 1'b1;
         phase_d = 1'b0;
      end else begin
         case (state_q)
            ST_ADDR: if (scl_rise) begin
               shift_d = rx_byte;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rw_d    = rx_byte[0];
                  phase_d = 1'b0;
                  state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
               end
            end
            ST_ADDR_ACK: if (scl_fall) begin
               if (!phase_q) begin
                  oe_d    = 1'b1;
                  phase_d = 1'b1;
                  if (rw_q) begin
                     snap_msb_d = temp_msb;
                     snap_lsb_d = temp_lsb;
                  end
               end else begin
                  phase_d = 1'b0;
                  if (rw_q) begin
                     state_d = ST_RD_BYTE;
                     oe_d    = ~rd_data[7];
                     tx_d    = {rd_data[6:0], 1'b0};
                     cnt_d   = 3'd1;
                  end else begin
                     state_d = ST_WR_BYTE;
                     oe_d    = 1'b0;
                     cnt_d   = 3'd0;
                     first_d = 1'b1;
                  end
               end
            end
            ST_WR_BYTE: if (scl_rise) begin
               shift_d = rx_byte;
               cnt_d   = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (first_q) begin
                     ptr_d   = rx_byte;
                     first_d = 1'b0;
                  end else if (ptr_q == REG_CFG) begin
                     cfg_d = rx_byte;
                  end
                  phase_d = 1'b0;
                  state_d = ST_WR_ACK;
               end
            end
            ST_WR_ACK: if (scl_fall) begin
               oe_d    = ~phase_q;
               phase_d = ~phase_q;
               if (phase_q) state_d = ST_WR_BYTE;
            end
            ST_RD_BYTE: if (scl_fall) begin
               if (cnt_q == 3'd0) begin
                  oe_d    = 1'b0;
                  phase_d = 1'b0;
                  state_d = ST_RD_ACK;
               end else begin
                  oe_d  = ~tx_q[7];
                  tx_d  = {tx_q[6:0], 1'b0};
                  cnt_d = cnt_q + 3'd1;
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_d = ST_IGNORE;
                  end else begin
                     ptr_d   = ptr_q + 8'd1;
                     phase_d = 1'b1;
                  end
               end else if (scl_fall && phase_q) begin
                  phase_d = 1'b0;
                  state_d = ST_RD_BYTE;
                  oe_d    = ~rd_data[7];
                  tx_d    = {rd_data[6:0], 1'b0};
                  cnt_d   = 3'd1;
               end
            end
            ST_IDLE, ST_IGNORE: ;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign sda_oe    = oe_q;
   assign cfg_reg   = cfg_q;
   assign busy      = busy_q;
   assign xfer_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_temp_target.sv
// ============================================================================
// tb_i2c_temp_target : directed I2C master bench for i2c_temp_target
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_temp_target;

   localparam int Q = 100;   // quarter SCL period in ns (SCL = 40 sys_clk cycles)

   logic       sys_clk  = 1'b0;
   logic       rst      = 1'b1;
   logic       scl      = 1'b1;
   logic       m_sda    = 1'b1;
   logic [7:0] temp_msb = 8'h19;
   logic [7:0] temp_lsb = 8'h80;
   wire        sda_oe, busy, xfer_done;
   wire  [7:0] cfg_reg;
   wire        sda_bus = m_sda & ~sda_oe;

   int n_chk = 0, n_pass = 0, done_cnt = 0, oe_cnt = 0;

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) begin
      if (xfer_done) done_cnt <= done_cnt + 1;
      if (sda_oe)    oe_cnt   <= oe_cnt + 1;
   end

   i2c_temp_target dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .scl_in    (scl),
      .sda_in    (sda_bus),
      .sda_oe    (sda_oe),
      .temp_msb  (temp_msb),
      .temp_lsb  (temp_lsb),
      .cfg_reg   (cfg_reg),
      .busy      (busy),
      .xfer_done (xfer_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; #Q;
      scl   = 1'b1; #Q;
      m_sda = 1'b0; #Q;
      scl   = 1'b0; #Q;
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; #Q;
      scl   = 1'b1; #Q;
      m_sda = 1'b1; #Q;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) begin
         m_sda = b[i]; #Q;
         scl = 1'b1; #Q;
         #Q;
         scl = 1'b0; #Q;
      end
      m_sda = 1'b1; #Q;
      scl = 1'b1; #Q;
      ack = sda_bus; #Q;
      scl = 1'b0; #Q;
   endtask

   task automatic wr(input string tag, input logic [7:0] b);
      logic ack;
      send_byte(b, ack);
      check(tag, ack, 1'b0);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack_bit);
      m_sda = 1'b1;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #Q; scl = 1'b1;
         #Q; d = {d[6:0], sda_bus};
         #Q; scl = 1'b0;
         #Q;
      end
      m_sda = ack_bit; #Q;
      scl = 1'b1; #Q;
      #Q;
      scl = 1'b0; #Q;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       ack;
      int         base;

      repeat (5) @(posedge sys_clk);
      #1;
      check("rst_sda_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", xfer_done, 1'b0);
      check("rst_cfg", cfg_reg, 8'h00);
      @(negedge sys_clk) rst = 1'b0;
      repeat (5) @(posedge sys_clk);

      // Scenario 1: temperature read with repeated start
      base = done_cnt;
      i2c_start();
      check("s1_busy", busy, 1'b1);
      wr("s1_ack_addr_w", 8'h90);
      wr("s1_ack_ptr", 8'h00);
      i2c_start();
      wr("s1_ack_addr_r", 8'h91);
      read_byte(d, 1'b0); check("s1_msb", d, 8'h19);
      read_byte(d, 1'b1); check("s1_lsb", d, 8'h80);
      i2c_stop();
      #(Q);
      check("s1_done_pulses", done_cnt - base, 1);
      check("s1_busy_after", busy, 1'b0);

      // Scenario 2: wrong address is ignored
      base = oe_cnt;
      i2c_start();
      send_byte(8'h92, ack);
      check("s2_nack", ack, 1'b1);
      wr_dummy: begin
         send_byte(8'h00, ack);
         check("s2_nack_data", ack, 1'b1);
      end
      i2c_stop();
      #(Q);
      check("s2_oe_cycles", oe_cnt - base, 0);

      // Scenario 3: config write and readback
      i2c_start();
      wr("s3_ack_addr", 8'h90);
      wr("s3_ack_ptr", 8'h03);
      wr("s3_ack_data", 8'hA0);
      check("s3_cfg", cfg_reg, 8'hA0);
      i2c_stop();
      i2c_start();
      wr("s3_rb_addr_w", 8'h90);
      wr("s3_rb_ptr", 8'h03);
      i2c_start();
      wr("s3_rb_addr_r", 8'h91);
      read_byte(d, 1'b1); check("s3_readback", d, 8'hA0);
      i2c_stop();

      // Scenario 4: ID register, pointer kept across a STOP
      i2c_start();
      wr("s4_ack_addr", 8'h90);
      wr("s4_ack_ptr", 8'h0B);
      i2c_stop();
      i2c_start();
      wr("s4_ack_addr_r", 8'h91);
      read_byte(d, 1'b1); check("s4_id", d, 8'hCB);
      i2c_stop();

      // Scenario 5: pointer wraps 0xFF -> 0x00
      i2c_start();
      wr("s5_ack_addr", 8'h90);
      wr("s5_ack_ptr", 8'hFF);
      i2c_stop();
      i2c_start();
      wr("s5_ack_addr_r", 8'h91);
      read_byte(d, 1'b0); check("s5_reg_ff", d, 8'h00);
      read_byte(d, 1'b0); check("s5_reg_00", d, 8'h19);
      read_byte(d, 1'b1); check("s5_reg_01", d, 8'h80);
      i2c_stop();

      // Scenario 6: reset while the target drives a 0 bit
      i2c_start();
      wr("s6_ack_addr", 8'h90);
      wr("s6_ack_ptr", 8'h00);
      i2c_start();
      wr("s6_ack_addr_r", 8'h91);
      check("s6_driving_zero", sda_oe, 1'b1);
      @(negedge sys_clk) rst = 1'b1;
      @(posedge sys_clk) #1;
      check("s6_oe_released", sda_oe, 1'b0);
      check("s6_cfg_cleared", cfg_reg, 8'h00);
      check("s6_busy_cleared", busy, 1'b0);
      @(negedge sys_clk) rst = 1'b0;
      #(4*Q);
      i2c_stop();
      i2c_start();
      wr("s6_re_addr_w", 8'h90);
      wr("s6_re_ptr", 8'h00);
      i2c_start();
      wr("s6_re_addr_r", 8'h91);
      read_byte(d, 1'b0); check("s6_re_msb", d, 8'h19);
      read_byte(d, 1'b1); check("s6_re_lsb", d, 8'h80);
      i2c_stop();

      // Scenario 7: snapshot coherency
      i2c_start();
      wr("s7_ack_addr_w", 8'h90);
      wr("s7_ack_ptr", 8'h00);
      i2c_start();
      wr("s7_ack_addr_r", 8'h91);
      read_byte(d, 1'b0); check("s7_msb", d, 8'h19);
      temp_msb = 8'h55;
      temp_lsb = 8'h66;
      read_byte(d, 1'b1); check("s7_lsb_snap", d, 8'h80);
      i2c_stop();
      i2c_start();
      wr("s7_new_addr_w", 8'h90);
      wr("s7_new_ptr", 8'h00);
      i2c_start();
      wr("s7_new_addr_r", 8'h91);
      read_byte(d, 1'b0); check("s7_new_msb", d, 8'h55);
      read_byte(d, 1'b1); check("s7_new_lsb", d, 8'h66);
      i2c_stop();
      #(4*Q);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
